// File: rtl/timer_bank.sv
// Bank of independent prescaled timer channels, each one-shot or periodic,
// sharing a single prescaler tick.
module timer_bank #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PRE_W  = 8
) (
  input  logic                    sb_clk,
  input  logic                    rst,
  input  logic [PRE_W-1:0]        tick_div,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       ch_clr,
  input  logic [NUM_CH-1:0]       ch_mode,
  input  logic [NUM_CH*CNT_W-1:0] ch_limit,
  output logic [NUM_CH*CNT_W-1:0] ch_count,
  output logic [NUM_CH-1:0]       expired,
  output logic [NUM_CH-1:0]       expired_pulse,
  output logic                    any_expired
);

  localparam int unsigned INC_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              tick_c;
  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  count_q [NUM_CH];
  logic [CNT_W-1:0]  count_d [NUM_CH];
  logic [NUM_CH-1:0] expired_q, expired_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic              any_q, any_d;
  logic [CNT_W-1:0]  limit_c;
  logic [INC_W-1:0]  inc_c;

  // Shared prescaler: tick on the cycle the counter reaches tick_div.
  always_comb begin
    tick_c = (pre_q >= tick_div);
    pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
  end

  // Per-channel next state; enable/limit gate first, then clear, then tick.
  always_comb begin
    expired_d = expired_q;
    pulse_d   = '0;
    limit_c   = '0;
    inc_c     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      limit_c    = ch_limit[i*CNT_W +: CNT_W];
      // Extra bit keeps the >= compare honest when count is at full scale.
      inc_c      = {1'b0, count_q[i]} + INC_W'(1);
      if (!ch_en[i] || (limit_c == '0)) begin
        state_d[i]   = S_IDLE;
        count_d[i]   = '0;
        expired_d[i] = 1'b0;
      end else if (ch_clr[i]) begin
        state_d[i]   = S_RUN;
        count_d[i]   = '0;
        expired_d[i] = 1'b0;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            state_d[i] = S_RUN;
            count_d[i] = '0;
          end
          S_RUN: begin
            if (tick_c) begin
              if (inc_c >= {1'b0, limit_c}) begin
                pulse_d[i] = 1'b1;
                if (ch_mode[i]) begin
                  count_d[i] = '0;
                end else begin
                  count_d[i]   = limit_c;
                  expired_d[i] = 1'b1;
                  state_d[i]   = S_DONE;
                end
              end else begin
                count_d[i] = inc_c[CNT_W-1:0];
              end
            end
          end
          S_DONE: begin
            state_d[i] = S_DONE;
          end
          default: begin
            state_d[i]   = S_IDLE;
            count_d[i]   = '0;
            expired_d[i] = 1'b0;
          end
        endcase
      end
    end
    any_d = |(expired_d | pulse_d);
  end

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      pre_q     <= '0;
      expired_q <= '0;
      pulse_q   <= '0;
      any_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        count_q[i] <= '0;
      end
    end else begin
      pre_q     <= pre_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
      any_q     <= any_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_count_out
    assign ch_count[g*CNT_W +: CNT_W] = count_q[g];
  end

  assign expired       = expired_q;
  assign expired_pulse = pulse_q;
  assign any_expired   = any_q;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: cycle model compared every cycle plus
// directed scenarios with hand-computed expectations.
module tb_timer_bank;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PRE_W  = 8;

  logic                    sb_clk = 1'b0;
  logic                    rst;
  logic [PRE_W-1:0]        tick_div;
  logic [NUM_CH-1:0]       ch_en, ch_clr, ch_mode;
  logic [NUM_CH*CNT_W-1:0] ch_limit;
  logic [NUM_CH*CNT_W-1:0] ch_count;
  logic [NUM_CH-1:0]       expired, expired_pulse;
  logic                    any_expired;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .sb_clk(sb_clk), .rst(rst), .tick_div(tick_div), .ch_en(ch_en),
    .ch_clr(ch_clr), .ch_mode(ch_mode), .ch_limit(ch_limit),
    .ch_count(ch_count), .expired(expired), .expired_pulse(expired_pulse),
    .any_expired(any_expired)
  );

  always #5 sb_clk = ~sb_clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic longint get_cnt(input int ch);
    return longint'(ch_count[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic set_lim(input int ch, input int v);
    ch_limit[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  // Behavioural model: integers and flags, evaluated from the rules each edge.
  int m_pre;
  int m_cnt  [NUM_CH];
  bit m_on   [NUM_CH];
  bit m_done [NUM_CH];
  bit m_pul  [NUM_CH];
  bit m_any;

  always @(posedge sb_clk) begin
    bit tick;
    int lim;
    tick = (m_pre >= int'(tick_div));
    m_any = 1'b0;
    if (rst) begin
      m_pre = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = 0; m_on[i] = 0; m_done[i] = 0; m_pul[i] = 0;
      end
    end else begin
      m_pre = tick ? 0 : m_pre + 1;
      for (int i = 0; i < NUM_CH; i++) begin
        lim = int'(ch_limit[i*CNT_W +: CNT_W]);
        m_pul[i] = 0;
        if (!ch_en[i] || lim == 0) begin
          m_on[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
        end else if (ch_clr[i]) begin
          m_on[i] = 1; m_done[i] = 0; m_cnt[i] = 0;
        end else if (!m_on[i]) begin
          m_on[i] = 1; m_cnt[i] = 0;
        end else if (!m_done[i] && tick) begin
          if (m_cnt[i] + 1 >= lim) begin
            m_pul[i] = 1;
            if (ch_mode[i]) m_cnt[i] = 0;
            else begin m_cnt[i] = lim; m_done[i] = 1; end
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        m_any = m_any | m_done[i] | m_pul[i];
      end
    end
  end

  always @(negedge sb_clk) begin
    if (chk_on) begin
      for (int i = 0; i < NUM_CH; i++) begin
        check($sformatf("model_ch%0d_count", i), get_cnt(i), m_cnt[i]);
        check($sformatf("model_ch%0d_expired", i), expired[i], m_done[i]);
        check($sformatf("model_ch%0d_pulse", i), expired_pulse[i], m_pul[i]);
      end
      check("model_any_expired", any_expired, m_any);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, npul, prev, k;
    rst = 1'b1; tick_div = '0; ch_en = '0; ch_clr = '0; ch_mode = '0; ch_limit = '0;
    repeat (2) @(negedge sb_clk);
    check("reset_count", longint'(ch_count), 0);
    check("reset_expired", expired, 0);
    check("reset_pulse", expired_pulse, 0);
    check("reset_any", any_expired, 0);
    rst = 1'b0;
    chk_on = 1'b1;

    // One-shot ch0, limit 5, tick every cycle.
    set_lim(0, 5); ch_mode[0] = 1'b0; ch_en[0] = 1'b1;
    first = -1; npul = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge sb_clk);
      if (expired_pulse[0]) begin npul++; if (first < 0) first = j; end
    end
    check("t1_pulse_cycle", first, 6);
    check("t1_pulse_count", npul, 1);
    check("t1_expired_held", expired[0], 1);
    check("t1_count", get_cnt(0), 5);
    ch_en[0] = 1'b0;
    @(negedge sb_clk);
    check("t1_disable_count", get_cnt(0), 0);
    check("t1_disable_expired", expired[0], 0);

    // Periodic ch1, limit 2, tick every 4 cycles.
    tick_div = 8'd3; set_lim(1, 2); ch_mode[1] = 1'b1; ch_en[1] = 1'b1;
    prev = -1; npul = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge sb_clk);
      check("t2_expired_level", expired[1], 0);
      if (expired_pulse[1]) begin
        if (prev >= 0) check("t2_pulse_gap", j - prev, 8);
        prev = j; npul++;
      end
    end
    check("t2_enough_pulses", (npul >= 4) ? 1 : 0, 1);
    ch_en[1] = 1'b0; ch_mode[1] = 1'b0; tick_div = '0;
    @(negedge sb_clk);

    // Clear coincident with tick at count 3.
    set_lim(0, 6); ch_en[0] = 1'b1;
    repeat (4) @(negedge sb_clk);
    check("t3_pre_clear_count", get_cnt(0), 3);
    ch_clr[0] = 1'b1;
    @(negedge sb_clk);
    ch_clr[0] = 1'b0;
    check("t3_clear_count", get_cnt(0), 0);
    first = -1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge sb_clk);
      if (expired_pulse[0] && first < 0) first = j;
    end
    check("t3_expiry_after_clear", first, 6);
    ch_en[0] = 1'b0;
    @(negedge sb_clk);

    // Lowering limit under the running count.
    set_lim(2, 20); ch_mode[2] = 1'b0; ch_en[2] = 1'b1;
    repeat (11) @(negedge sb_clk);
    check("t4_count_before", get_cnt(2), 10);
    set_lim(2, 4);
    @(negedge sb_clk);
    check("t4_pulse", expired_pulse[2], 1);
    check("t4_count", get_cnt(2), 4);
    check("t4_expired", expired[2], 1);
    ch_en[2] = 1'b0;
    @(negedge sb_clk);

    // Simultaneous expiry on ch0 (one-shot) and ch3 (periodic).
    set_lim(0, 3); set_lim(3, 3); ch_mode[0] = 1'b0; ch_mode[3] = 1'b1;
    ch_en = 4'b1001;
    k = 0;
    do begin
      @(negedge sb_clk);
      k++;
    end while (expired_pulse == '0 && k < 10);
    check("t5_latency", k, 4);
    check("t5_pulse_vec", expired_pulse, 4'b1001);
    check("t5_any", any_expired, 1);
    @(negedge sb_clk);
    check("t5_pulse_drop", expired_pulse, 0);
    check("t5_expired_vec", expired, 4'b0001);
    ch_en = '0; ch_mode = '0;
    @(negedge sb_clk);

    // Reset while ch0 is done and ch1 is running.
    set_lim(0, 2); set_lim(1, 100); ch_en = 4'b0011;
    repeat (10) @(negedge sb_clk);
    check("t6_ch0_done", expired[0], 1);
    check("t6_ch1_count", get_cnt(1), 9);
    rst = 1'b1;
    @(negedge sb_clk);
    check("t6_rst_count", longint'(ch_count), 0);
    check("t6_rst_expired", expired, 0);
    check("t6_rst_pulse", expired_pulse, 0);
    check("t6_rst_any", any_expired, 0);
    rst = 1'b0;
    repeat (3) @(negedge sb_clk);
    check("t6_resume_ch1", get_cnt(1), 2);
    check("t6_resume_ch0", get_cnt(0), 2);
    check("t6_resume_pulse0", expired_pulse[0], 1);
    ch_en = '0;
    @(negedge sb_clk);

    // Mixed traffic: zero limit, prescaled periodic, clear from done, enable drop.
    tick_div = 8'd2;
    set_lim(0, 7); ch_mode[0] = 1'b1;
    set_lim(2, 3); ch_mode[2] = 1'b0;
    set_lim(3, 0);
    ch_en = 4'b1101;
    repeat (15) @(negedge sb_clk);
    check("t7_zero_limit_count", get_cnt(3), 0);
    ch_clr[2] = 1'b1;
    @(negedge sb_clk);
    ch_clr[2] = 1'b0;
    check("t7_clr_from_done", expired[2], 0);
    repeat (7) @(negedge sb_clk);
    ch_en[0] = 1'b0;
    repeat (12) @(negedge sb_clk);
    check("t7_ch0_idle", get_cnt(0), 0);
    ch_en = '0;
    @(negedge sb_clk);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
